// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM state encodings and a
// counter-width helper used to size the layer and timeout counters.
package layer_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Minimum one bit even when the count collapses to a single value.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/layer_sequencer_done_collector.sv
// Sticky per-unit done capture with synchronous clear; reports layer completion
// including dones arriving in the current cycle, and the still-missing units.
module layer_sequencer_done_collector #(
    parameter int NUM_UNITS = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [NUM_UNITS-1:0] dones,
    output logic                 all_captured,
    output logic [NUM_UNITS-1:0] missing
);

    logic [NUM_UNITS-1:0] capture_r;
    logic [NUM_UNITS-1:0] merged_s;

    assign merged_s     = capture_r | dones;
    assign all_captured = &merged_s;
    assign missing      = ~merged_s;

    // Capture flags: cleared outside the wait window, OR-accumulated inside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            capture_r <= {NUM_UNITS{1'b0}};
        end else if (clr) begin
            capture_r <= {NUM_UNITS{1'b0}};
        end else if (en) begin
            capture_r <= merged_s;
        end else begin
            capture_r <= capture_r;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences NUM_LAYERS layers over a shared array of compute units: issues a
// start pulse per layer, collects all unit dones, and flags units that time out.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int  NUM_UNITS      = 4,
    parameter int  NUM_LAYERS     = 3,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int LW             = cnt_width(NUM_LAYERS),
    localparam int TW             = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 clear,
    input  logic [NUM_UNITS-1:0] unit_dones,
    output logic                 unit_start,
    output logic [LW-1:0]        layer_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_UNITS-1:0] missing
);

    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_r;
    logic [1:0]           state_n;
    logic [LW-1:0]        layer_r;
    logic [LW-1:0]        layer_n;
    logic [TW-1:0]        tmo_r;
    logic [TW-1:0]        tmo_n;
    logic                 done_n;
    logic [NUM_UNITS-1:0] missing_r;
    logic [NUM_UNITS-1:0] missing_n;
    logic                 unit_start_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 error_r;
    logic                 all_captured_s;
    logic [NUM_UNITS-1:0] missing_s;
    logic                 coll_clr_s;
    logic                 coll_en_s;

    // Every state other than WAIT leaves the flags clear, so each WAIT starts empty.
    assign coll_en_s  = (state_r == ST_WAIT);
    assign coll_clr_s = (state_r != ST_WAIT);

    layer_sequencer_done_collector #(
        .NUM_UNITS (NUM_UNITS)
    ) u_collector (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (coll_clr_s),
        .en           (coll_en_s),
        .dones        (unit_dones),
        .all_captured (all_captured_s),
        .missing      (missing_s)
    );

    // Next-state, layer, timeout and fault-snapshot logic.
    always_comb begin
        state_n   = state_r;
        layer_n   = layer_r;
        tmo_n     = tmo_r;
        done_n    = 1'b0;
        missing_n = missing_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_n = ST_IDLE;
                end else if (start) begin
                    state_n = ST_ISSUE;
                    layer_n = {LW{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    layer_n = {LW{1'b0}};
                end else begin
                    state_n = ST_WAIT;
                    tmo_n   = {TW{1'b0}};
                end
            end
            ST_WAIT: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    layer_n = {LW{1'b0}};
                end else if (all_captured_s) begin
                    if (layer_r == LAST_LAYER) begin
                        state_n = ST_IDLE;
                        layer_n = {LW{1'b0}};
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                        layer_n = layer_r + LW'(1);
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_n   = ST_FAULT;
                    missing_n = missing_s;
                end else begin
                    tmo_n = tmo_r + TW'(1);
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    state_n   = ST_IDLE;
                    layer_n   = {LW{1'b0}};
                    missing_n = {NUM_UNITS{1'b0}};
                end else begin
                    state_n = ST_FAULT;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                layer_n   = {LW{1'b0}};
                missing_n = {NUM_UNITS{1'b0}};
            end
        endcase
    end

    // State and output registers; outputs derive from the next state so they align with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            layer_r      <= {LW{1'b0}};
            tmo_r        <= {TW{1'b0}};
            missing_r    <= {NUM_UNITS{1'b0}};
            unit_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            layer_r      <= layer_n;
            tmo_r        <= tmo_n;
            missing_r    <= missing_n;
            unit_start_r <= (state_n == ST_ISSUE);
            busy_r       <= (state_n == ST_ISSUE) || (state_n == ST_WAIT);
            done_r       <= done_n;
            error_r      <= (state_n == ST_FAULT);
        end
    end

    assign unit_start = unit_start_r;
    assign layer_idx  = layer_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign missing    = missing_r;

endmodule
